// File: rtl/instr_prefetch_if.sv
// Fetch-unit bus: decode-side stall/redirect/head outputs plus the imem read port.
// The slave modport is the prefetch queue; the master is its environment.
interface instr_prefetch_if;
  logic        stall;
  logic        branch;
  logic [15:0] branchAddr;
  logic        imem_rd_en;
  logic [15:0] imem_addr;
  logic        imem_vld;
  logic [15:0] imem_rdata;
  logic        instr_vld;
  logic [15:0] instr;
  logic [15:0] pc;
  logic [15:0] pcNext;
  logic        fetch_halted;

  modport master (
    output stall, branch, branchAddr, imem_vld, imem_rdata,
    input  imem_rd_en, imem_addr, instr_vld, instr, pc, pcNext, fetch_halted
  );

  modport slave (
    input  stall, branch, branchAddr, imem_vld, imem_rdata,
    output imem_rd_en, imem_addr, instr_vld, instr, pc, pcNext, fetch_halted
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: in-order imem reads buffered in a DEPTH-entry FIFO.
// Optional halt detection (opcode nibble 4'hF) is enabled by defining HLT_DETECT_EN.
module instr_prefetch_queue #(
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2,
  parameter logic [15:0] RESET_PC  = 16'h0000
) (
  input logic             clk,
  input logic             rst_n,
  instr_prefetch_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int AW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef enum logic {FETCH, HALTED} state_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } entry_t;

  state_t        state;
  logic [15:0]   fetch_pc;
  entry_t        fifo [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [15:0]   addr_q [MAX_OUTST];
  logic [AW-1:0] aq_rd;
  logic [AW-1:0] aq_wr;
  logic [OW-1:0] outst;
  logic [OW-1:0] drop_cnt;
  logic [OW-1:0] outst_next;
  logic [CW:0]   in_use;
  logic [15:0]   pc_hold;
  logic [15:0]   head_pc;
  logic          head_vld;
  logic          issue;
  logic          push;
  logic          pop;
  logic          halt_hit;

  function automatic logic [AW-1:0] aq_next(input logic [AW-1:0] p);
    return (p == AW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  // Slots already claimed: buffered entries plus reads that will still be kept.
  assign in_use     = (CW+1)'(count) + (CW+1)'(outst - drop_cnt);
  assign issue      = rst_n && (state == FETCH) && !bus.branch &&
                      (outst < OW'(MAX_OUTST)) && (in_use < (CW+1)'(DEPTH));
  assign push       = bus.imem_vld && (drop_cnt == '0) && !bus.branch;
  assign head_vld   = (count != '0);
  assign pop        = head_vld && !bus.stall && !bus.branch;
  assign outst_next = outst + OW'(issue) - OW'(bus.imem_vld);

`ifdef HLT_DETECT_EN
  assign halt_hit         = push && (bus.imem_rdata[15:12] == 4'hF);
  assign bus.fetch_halted = (state == HALTED);
`else
  assign halt_hit         = 1'b0;
  assign bus.fetch_halted = 1'b0;
`endif

  assign head_pc        = head_vld ? fifo[rd_ptr].pc : pc_hold;
  assign bus.instr_vld  = head_vld;
  assign bus.instr      = head_vld ? fifo[rd_ptr].instr : 16'h0000;
  assign bus.pc         = head_pc;
  assign bus.pcNext     = head_pc + 16'd1;
  assign bus.imem_rd_en = issue;
  assign bus.imem_addr  = fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      aq_rd    <= '0;
      aq_wr    <= '0;
      outst    <= '0;
      drop_cnt <= '0;
      pc_hold  <= RESET_PC;
      // NOTE: storage is cleared too; the imem model shares this reset and
      // pending responses vanish, so no stale entry may survive it.
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
      for (int i = 0; i < MAX_OUTST; i++) addr_q[i] <= '0;
    end else begin
      // NOTE: non-blocking throughout so every term reads pre-edge state.
      outst <= outst_next;
      if (issue) begin
        addr_q[aq_wr] <= fetch_pc;
        aq_wr         <= aq_next(aq_wr);
      end
      // Every response retires its address slot, whether kept or dropped.
      if (bus.imem_vld) aq_rd <= aq_next(aq_rd);
      if (head_vld) pc_hold <= fifo[rd_ptr].pc;

      if (bus.branch) begin
        fetch_pc <= bus.branchAddr;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        drop_cnt <= outst_next;
        state    <= FETCH;
      end else begin
        if (issue) fetch_pc <= fetch_pc + 16'd1;
        if (push) begin
          fifo[wr_ptr] <= '{pc: addr_q[aq_rd], instr: bus.imem_rdata};
          wr_ptr       <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
        // Reads past a halt are discarded, including one issued this cycle.
        if (halt_hit) begin
          state    <= HALTED;
          drop_cnt <= outst_next;
        end else if (bus.imem_vld && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - 1'b1;
        end
      end
    end
  end
endmodule
